// File: rtl/ej32_pkg.sv
// Shared eJ32 types and constants used by the store serializer.
package ej32_pkg;

  typedef enum logic [0:0] {
    wIDLE = 1'b0,
    wBYTE = 1'b1
  } wr_state;

  // Store sizes for bastore / sastore / iastore.
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_S = 3'd2;
  localparam logic [2:0] ST_I = 3'd4;

  function automatic logic st_n_legal(input logic [2:0] n);
    return (n != 3'd0) && (n <= ST_I);
  endfunction

  function automatic logic st_misaligned(input logic [2:0] n, input logic [1:0] a_lo);
    return ((n == ST_S) && a_lo[0]) || ((n == ST_I) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ej32_mem_wr.sv
// Big-endian store serializer: writes 1..4 bytes of a stack value onto the byte bus.
// Build option: EJ32_MEM_WR_ALIGN_EN rejects misaligned 2- and 4-byte stores.
module ej32_mem_wr
  import ej32_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st_req,
  input  logic [2:0]     st_n,
  input  logic [ASZ-1:0] st_addr,
  input  logic [DSZ-1:0] st_data,
  input  logic           mem_wait,
  output logic           st_rdy,
  output logic           st_done,
  output logic           st_err,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_addr,
  output logic [7:0]     mem_data
);

  wr_state        r_state;
  logic [DSZ-1:0] r_sr;
  logic [ASZ-1:0] r_addr;
  logic [1:0]     r_cnt;
  logic           r_done;
  logic           r_err;

  wr_state        w_state_next;
  logic [DSZ-1:0] w_sr_next;
  logic [ASZ-1:0] w_addr_next;
  logic [1:0]     w_cnt_next;
  logic           w_done_next;
  logic           w_err_next;

  logic           w_rdy;
  logic           w_reject;
  logic [DSZ-1:0] w_sr_init;
  logic           w_busy;

`ifdef EJ32_MEM_WR_ALIGN_EN
  assign w_reject = !st_n_legal(st_n) || st_misaligned(st_n, st_addr[1:0]);
`else
  assign w_reject = !st_n_legal(st_n);
`endif

  // The error cycle also blocks acceptance so st_rdy is low for exactly one cycle.
  assign w_rdy  = (r_state == wIDLE) && !r_err;
  assign w_busy = (r_state == wBYTE);

  // Left-align the stored bytes so the first bus byte is always the top lane.
  always_comb begin
    w_sr_init = '0;
    case (st_n)
      3'd1:    w_sr_init = st_data << 24;
      3'd2:    w_sr_init = st_data << 16;
      3'd3:    w_sr_init = st_data << 8;
      3'd4:    w_sr_init = st_data;
      default: w_sr_init = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_addr_next  = r_addr;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      wIDLE: begin
        if (st_req && w_rdy) begin
          if (w_reject) begin
            w_err_next = 1'b1;
          end else begin
            w_sr_next    = w_sr_init;
            w_addr_next  = st_addr;
            w_cnt_next   = 2'(st_n - 3'd1);
            w_state_next = wBYTE;
          end
        end
      end
      wBYTE: begin
        if (!mem_wait) begin
          w_sr_next   = r_sr << 8;
          w_addr_next = r_addr + ASZ'(1);
          w_cnt_next  = r_cnt - 2'd1;
          if (r_cnt == 2'd0) begin
            w_state_next = wIDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = wIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= wIDLE;
      r_sr    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_addr  <= w_addr_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign st_rdy   = w_rdy;
  assign st_done  = r_done;
  assign st_err   = r_err;
  assign mem_we   = w_busy;
  assign mem_addr = w_busy ? r_addr : '0;
  assign mem_data = w_busy ? r_sr[DSZ-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_ej32_mem_wr.sv
// Self-checking bench for ej32_mem_wr: vector table driver plus bus-write scoreboard.
module tb_ej32_mem_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_req = 1'b0;
  logic [2:0]  st_n = 3'd0;
  logic [16:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        mem_wait = 1'b0;
  logic        st_rdy, st_done, st_err, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;

  ej32_mem_wr #(.DSZ(32), .ASZ(17)) dut (
    .clk(clk), .rst(rst), .st_req(st_req), .st_n(st_n), .st_addr(st_addr),
    .st_data(st_data), .mem_wait(mem_wait), .st_rdy(st_rdy), .st_done(st_done),
    .st_err(st_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  n;
    logic [16:0] addr;
    logic [31:0] data;
    int          stall;
    bit          exp_err;
    int          exp_cyc;
    bit          b2b;
  } vec_t;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got write 0x%0h@0x%0h, required no write (t=%0t)",
                 mem_data, mem_addr, $time);
      end else begin
        check("wr_addr", 64'(mem_addr), 64'(exp_q[0].a));
        check("wr_data", 64'(mem_data), 64'(exp_q[0].d));
        if (!mem_wait) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_bytes(input logic [2:0] n, input logic [16:0] a, input logic [31:0] d);
    wr_t w;
    for (int i = 0; i < int'(n); i++) begin
      w.a = a + 17'(i);
      w.d = 8'(d >> (8 * (int'(n) - 1 - i)));
      exp_q.push_back(w);
    end
  endtask

  task automatic run(input vec_t v);
    int  c;
    int  budget;
    bit  seen;
    budget = 0;
    if (v.b2b) check("b2b_rdy_in_done_cycle", 64'(st_rdy), 64'd1);
    while (!st_rdy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("rdy_before_req", 64'(st_rdy), 64'd1);
    st_req  = 1'b1;
    st_n    = v.n;
    st_addr = v.addr;
    st_data = v.data;
    if (!v.exp_err) push_bytes(v.n, v.addr, v.data);
    @(posedge clk);
    #1;
    st_req  = 1'b0;
    st_addr = 17'($urandom());
    st_data = $urandom();
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 20) begin
      mem_wait = (c == v.stall);
      @(negedge clk);
      check("done_err_exclusive", 64'(st_done & st_err), 64'd0);
      if (st_done || st_err) begin
        seen = 1'b1;
        check("event_cycle", 64'(c), 64'(v.exp_cyc));
        check("event_is_err", 64'(st_err), 64'(v.exp_err));
      end else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    if (!seen) check("event_timeout", 64'd0, 64'd1);
    if (v.exp_err) begin
      check("rdy_low_in_err_cycle", 64'(st_rdy), 64'd0);
      @(negedge clk);
      check("rdy_back_after_err", 64'(st_rdy), 64'd1);
    end
  endtask

  vec_t vt[12];
  bit   align_en;

  initial begin
`ifdef EJ32_MEM_WR_ALIGN_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    //         n     addr        data           stall err  cyc  b2b
    vt[0]  = '{3'd4, 17'h00100, 32'hAABBCCDD, 0,    1'b0, 5,  1'b0};
    vt[1]  = '{3'd2, 17'h00200, 32'h12345678, 2,    1'b0, 4,  1'b0};
    vt[2]  = '{3'd1, 17'h1FFFF, 32'h000000EE, 0,    1'b0, 2,  1'b0};
    vt[3]  = '{3'd4, 17'h1FFFE, 32'h01020304, 0,    1'b0, 5,  1'b1};
    vt[4]  = '{3'd0, 17'h00010, 32'hDEADBEEF, 0,    1'b1, 1,  1'b0};
    vt[5]  = '{3'd6, 17'h00020, 32'hDEADBEEF, 0,    1'b1, 1,  1'b0};
    vt[6]  = '{3'd4, 17'h00102, 32'hCAFEF00D, 0,    align_en, align_en ? 1 : 5, 1'b0};
    vt[7]  = '{3'd3, 17'h00005, 32'h99ABCDEF, 0,    1'b0, 4,  1'b0};
    vt[8]  = '{3'd2, 17'h00201, 32'h0000BEEF, 0,    align_en, align_en ? 1 : 3, 1'b0};
    vt[9]  = '{3'd7, 17'h00030, 32'h11111111, 0,    1'b1, 1,  1'b0};
    vt[10] = '{3'd1, 17'h00040, 32'h0000005A, 1,    1'b0, 3,  1'b0};
    vt[11] = '{3'd2, 17'h00050, 32'hFFFFA55A, 3,    1'b0, 3,  1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", 64'(st_rdy), 64'd1);
    check("reset_done", 64'(st_done), 64'd0);
    check("reset_err", 64'(st_err), 64'd0);
    check("reset_we", 64'(mem_we), 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_data", 64'(mem_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      $display("vector %0d: n=%0d addr=0x%05h data=0x%08h stall=%0d", i, vt[i].n,
               vt[i].addr, vt[i].data, vt[i].stall);
      run(vt[i]);
    end

    // Reset in the middle of a 4-byte store: bytes 1 and 2 reach the bus, then nothing.
    @(negedge clk);
    st_req = 1'b1; st_n = 3'd4; st_addr = 17'h00300; st_data = 32'h11223344;
    push_bytes(3'd2, 17'h00300, 32'h00001122);
    @(posedge clk);
    #1;
    st_req = 1'b0;
    mem_wait = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_byte2_we", 64'(mem_we), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_we_low", 64'(mem_we), 64'd0);
      check("rst_mid_no_done", 64'(st_done), 64'd0);
    end
    check("rst_mid_rdy", 64'(st_rdy), 64'd1);
    $display("post-reset vector: n=4 addr=0x00400 data=0xA1B2C3D4");
    run('{3'd4, 17'h00400, 32'hA1B2C3D4, 0, 1'b0, 5, 1'b0});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ej32_mem_wr.md
# ej32_mem_wr

Store serializer for the eJ32 memory bus: takes one 32-bit stack value and a byte address, and writes 1, 2 or 4 bytes onto the 8-bit memory bus, one byte per cycle, in big-endian (Java) order. It is the write-direction counterpart of the arithmetic unit's byte-merging load path, which assembles bytes MSB-first into TOS. It sits between the control/AU pair (`iastore`, `sastore`, `bastore`, `put`) and the memory bus.

## Interface
Parameters:
- `DSZ`, default 32: data width; must be 32.
- `ASZ`, default 17: byte address width.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st_req` in 1: store request; sampled only while `st_rdy`=1.
- `st_n` in 3: byte count, legal values 1..4.
- `st_addr` in ASZ: base byte address.
- `st_data` in DSZ: value to store; the low `8*st_n` bits are written.
- `mem_wait` in 1: bus stall; hold the current byte while high.
- `st_rdy` out 1: idle, request can be accepted.
- `st_done` out 1: one-cycle pulse marking completion.
- `st_err` out 1: one-cycle pulse marking a rejected request.
- `mem_we` out 1: byte write strobe.
- `mem_addr` out ASZ: byte address.
- `mem_data` out 8: byte data.

## Operation
State machine with states `wIDLE` and `wBYTE`.

Reset values:
- State `wIDLE`.
- `st_rdy`=1.
- `st_done`, `st_err`, `mem_we` = 0.
- `mem_addr`, `mem_data` = 0.

Accept: when `st_req & st_rdy` is high at a clock edge:
- Latch the shift register `sr` = `st_data << (32 - 8*st_n)`, which left-aligns the value.
- Latch `addr` = `st_addr` and `cnt` = `st_n - 1`.
- Go to `wBYTE`.

In `wBYTE`:
- Drive `mem_we`=1, `mem_addr`=`addr`, `mem_data`=`sr[31:24]`, `st_rdy`=0.
- On each edge with `mem_wait`=0:
  - Shift `sr` left by 8.
  - Increment `addr` (wraps modulo 2^ASZ).
  - Decrement `cnt`.
  - If `cnt`==0, go to `wIDLE` and set `st_done` for the next cycle.

Byte order: for `st_n`=4 and value `0xAABBCCDD` at address A, the bus sees `AA`@A, `BB`@A+1, `CC`@A+2, `DD`@A+3. For `st_n`=2, only the low 16 bits are written, MSB byte first.

Illegal `st_n` (0 or 5..7):
- The request is accepted: `st_rdy` drops for one cycle.
- No bus write occurs.
- `st_err` pulses in the following cycle.

Edge cases:
- `st_req` while busy is ignored; the requester holds `st_req` and its operands until `st_rdy` is high.
- `mem_wait` in `wIDLE` has no effect.
- `rst` mid-transfer: at the reset edge, return to `wIDLE` and drop `mem_we` immediately. The partial write is not completed and `st_done` does not pulse.

## Timing
- Outputs are decoded from registered state only; there is no combinational path from `st_*` inputs to `mem_*` outputs.
- Edge 0 accepts the request. Bytes occupy cycles 1..n when there are no stalls, and each stall cycle adds one cycle.
- `st_done` is high in the first `wIDLE` cycle after the last byte, i.e. cycle n+1 when unstalled.
- In the `st_done` cycle `st_rdy`=1, so a back-to-back request accepted there starts bytes one cycle later. Sustained throughput is n bytes per n+1 cycles.
- `st_done` and `st_err` are never high in the same cycle.

## Configuration
- `EJ32_MEM_WR_ALIGN_EN` defined: alignment check is compiled in.
  - Rejected requests: `st_n`=2 with `st_addr[0]`≠0, and `st_n`=4 with `st_addr[1:0]`≠0.
  - A rejected request gets illegal-`st_n` handling: no write, `st_err` pulse.
  - `st_n`=1 and `st_n`=3 are never misaligned.
- `EJ32_MEM_WR_ALIGN_EN` undefined: any address is accepted. `st_err` flags only illegal `st_n`.

## Structure
- `ej32_pkg` gains:
  - `typedef enum` `wr_state` {`wIDLE`, `wBYTE`}.
  - Constants `ST_B`=1, `ST_S`=2, `ST_I`=4 for the `bastore`/`sastore`/`iastore` sizes.
- No sub-module is needed. The FSM, shift register, address counter and byte counter are inline, one `always_ff` plus one `always_comb` decode.

## Test plan
- Reset, then store 4 bytes of `0xAABBCCDD` at 0x0100 with no stalls → `mem_we` cycles 1-4 with bytes `AA`,`BB`,`CC`,`DD` @0x0100-0x0103; `st_done` in cycle 5.
- Store 2 bytes of `0x12345678` at 0x0200, `mem_wait` high in cycle 2 → bytes `56`@0x0200, `78`@0x0201 held for two cycles; `st_done` in cycle 4.
- Store 1 byte `0x000000EE` at 0x1FFFF, then a back-to-back 4-byte request in the `st_done` cycle → `EE`@0x1FFFF; next transfer starts the following cycle; a 4-byte store at 0x1FFFE wraps to 0x00000/0x00001.
- `st_n`=0 and `st_n`=6 → no `mem_we`; `st_err` pulse one cycle after accept; `st_rdy` low for exactly one cycle.
- With `EJ32_MEM_WR_ALIGN_EN`: 4-byte store at 0x0102 → `st_err` and no write. Without it → 4 bytes written @0x0102-0x0105.
- `rst` asserted during byte 2 of a 4-byte store → `mem_we`=0 from the reset edge; no `st_done`; a new request after reset completes normally.
